// File: rtl/fpu_sched_pkg.sv
// Shared types and helpers for the FPU negation scheduler.
// The package itself has no configuration macro.
package fpu_sched_pkg;

    // The output register either has room for a result or holds one.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;

    // Operand width used when the instantiating unit does not override it.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Width of a binary requester index. It is never less than one bit,
    // so a two-requester build still gets a real index bit.
    function automatic int id_width(input int num_req);
        int w;
        if (num_req <= 2) begin
            w = 1;
        end else begin
            w = $clog2(num_req);
        end
        return w;
    endfunction

endpackage

// File: rtl/negate_rr_scheduler_arbiter.sv
// Round-robin arbiter for the negation scheduler.
// The search starts at the pointer and wraps modulo NUM_REQ. After an
// accepted grant the pointer moves to the slot just past the winner.
module rr_arbiter
    import fpu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   index_s;
    logic               found_s;
    int                 cand_s;

    // Find the first valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        index_s = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = (int'(ptr_q) + k) % NUM_REQ;
            if (!found_s && valid_i[cand_s]) begin
                found_s         = 1'b1;
                grant_s[cand_s] = 1'b1;
                index_s         = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // After an accepted grant, point at the slot after the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (index_s == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = {IDX_W{1'b0}};
            end else begin
                ptr_d = index_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register. It holds when no grant is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o = grant_s;
    assign index_o = index_s;
    assign any_o   = found_s;

endmodule

// File: rtl/two_complement.sv
// Two's-complement negation: y = (~a + 1) mod 2^WIDTH.
// Negating zero gives zero. Negating the most-negative value gives that
// value back, because the result wraps.
module two_complement #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Invert the operand, then add one at the least significant bit.
    assign y = (~a) + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/negate_rr_scheduler.sv
// Shares one two's-complement negation unit among NUM_REQ FPU requesters.
// Requests are chosen round robin, and each result goes into a single
// output register with back-pressure.
// Optional feature: define NEG_OVF_FLAG_EN to add the out_ovf flag. It
// marks a negation of the most-negative operand.
module negate_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_neg,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
`ifdef NEG_OVF_FLAG_EN
    output logic                          out_ovf,
`endif
    output logic [ID_WIDTH-1:0]           out_id
);

    sched_state_e          state_q;
    sched_state_e          state_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ID_WIDTH-1:0]   out_id_q;

    logic [NUM_REQ-1:0]    grant_s;
    logic [ID_WIDTH-1:0]   gnt_idx_s;
    logic                  gnt_any_s;
    logic                  can_accept_s;
    logic                  handshake_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic                  gnt_neg_s;
    logic [DATA_WIDTH-1:0] neg_data_s;
    logic [DATA_WIDTH-1:0] result_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (req_valid),
        .advance_i (handshake_s),
        .grant_o   (grant_s),
        .index_o   (gnt_idx_s),
        .any_o     (gnt_any_s)
    );

    // A new result can enter when the register is free or is being drained.
    // rst_n is included so that req_ready reads zero for the whole reset.
    assign can_accept_s = ((state_q == EMPTY) | out_ready) & rst_n;
    assign req_ready    = grant_s & {NUM_REQ{can_accept_s}};
    assign handshake_s  = gnt_any_s & can_accept_s;

    // Route the granted operand through the shared negation unit.
    assign gnt_data_s = req_data[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    assign gnt_neg_s  = req_neg[gnt_idx_s];

    two_complement #(
        .WIDTH (DATA_WIDTH)
    ) u_neg (
        .a (gnt_data_s),
        .y (neg_data_s)
    );

    assign result_s = gnt_neg_s ? neg_data_s : gnt_data_s;

    // Next-state logic for the output register occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (handshake_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = handshake_s ? FULL : EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Load the result and requester id on every accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= {DATA_WIDTH{1'b0}};
            out_id_q   <= {ID_WIDTH{1'b0}};
        end else if (handshake_s) begin
            out_data_q <= result_s;
            out_id_q   <= gnt_idx_s;
        end else begin
            out_data_q <= out_data_q;
            out_id_q   <= out_id_q;
        end
    end

`ifdef NEG_OVF_FLAG_EN
    logic out_ovf_q;
    logic ovf_s;

    // Overflow: the operand is 1 followed by zeros and negation is requested.
    assign ovf_s = gnt_neg_s & (gnt_data_s == {1'b1, {(DATA_WIDTH-1){1'b0}}});

    // The overflow flag is registered together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_q <= 1'b0;
        end else if (handshake_s) begin
            out_ovf_q <= ovf_s;
        end else begin
            out_ovf_q <= out_ovf_q;
        end
    end

    assign out_ovf = out_ovf_q;
`endif

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_negate_rr_scheduler.sv
// Self-checking bench for negate_rr_scheduler. It runs directed cases and
// then random traffic. Expected values come from a transaction-level model.
module tb_negate_rr_scheduler;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_neg;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
`ifdef NEG_OVF_FLAG_EN
    logic              out_ovf;
`endif

    int checks_total;
    int checks_passed;

    // Reference model state: the pending result and the round-robin start.
    int m_valid;
    int m_data;
    int m_id;
    int m_ovf;
    int m_ptr;

    negate_rr_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NREQ),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_neg   (req_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef NEG_OVF_FLAG_EN
        .out_ovf   (out_ovf),
`endif
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_id    = 0;
        m_ovf   = 0;
        m_ptr   = 0;
    endtask

    // One clock cycle. It is entered and left at a falling edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [31:0] d,
                        input logic [NREQ-1:0] n, input logic r);
        int win;
        int x;
        logic [NREQ-1:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        req_neg   = n;
        out_ready = r;
        #1;
        win = -1;
        if (m_valid == 0 || r) begin
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (win >= 0) begin
            x       = int'(d[win*DW +: DW]);
            m_data  = n[win] ? ((256 - x) % 256) : x;
            m_ovf   = (n[win] && x == 128) ? 1 : 0;
            m_id    = win;
            m_valid = 1;
            m_ptr   = (win + 1) % NREQ;
        end else if (r) begin
            m_valid = 0;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_id", 32'(out_id), 32'(m_id));
`ifdef NEG_OVF_FLAG_EN
        check("out_ovf", 32'(out_ovf), 32'(m_ovf));
`endif
        @(negedge clk);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        model_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h0;
        req_neg   = 4'b0000;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: negate, then pass through.
        step(4'b0001, 32'h0000_0005, 4'b0001, 1'b1);
        check("neg5_value", 32'(out_data), 32'h0000_00FB);
        step(4'b0001, 32'h0000_0005, 4'b0000, 1'b1);
        check("pass5_value", 32'(out_data), 32'h0000_0005);
        // Boundary operands.
        step(4'b0001, 32'h0000_0000, 4'b0001, 1'b1);
        check("neg0_value", 32'(out_data), 32'h0000_0000);
        step(4'b0001, 32'h0000_0080, 4'b0001, 1'b1);
        check("neg80_value", 32'(out_data), 32'h0000_0080);
        step(4'b0001, 32'h0000_00FF, 4'b0001, 1'b1);
        check("negFF_value", 32'(out_data), 32'h0000_0001);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // All requesters valid: the model expects ids in strict rotation.
        for (int i = 0; i < 8; i++) step(4'b1111, 32'h4433_2211, 4'b1010, 1'b1);

        // Back-pressure for five cycles, then release.
        for (int i = 0; i < 5; i++) step(4'b1111, 32'h8877_6655, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1111, 32'h8877_6655, 4'b0101, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), $urandom, 4'($urandom), ($urandom_range(3, 0) != 0));
        end

        // Reset while the register is full and requests are pending.
        step(4'b0110, 32'h1234_5678, 4'b0010, 1'b1);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_out_id", 32'(out_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 32'hA0B0_C0D0, 4'b1111, 1'b1);
        check("post_rst_first_id", 32'(out_id), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/negate_rr_scheduler.md
Name: negate_rr_scheduler

Overview:
- Shares one two's-complement negation datapath (existing two_complement unit) between NUM_REQ requesters inside the FPU: mantissa subtract path, int-to-float convert and exponent-difference path.
- Round-robin arbitration on a valid/ready interface, with a single registered output stage and back-pressure.
- Each request either negates its operand or passes it through unchanged; the result carries the requester ID.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (>=2).
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of out_id; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_data  input  NUM_REQ*DATA_WIDTH  operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_neg  input  NUM_REQ  1 = negate operand, 0 = pass through.
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_WIDTH  result.
- out_id  output  ID_WIDTH  index of the requester that produced out_data.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, out_id=0, req_ready=0, rr pointer=0, FSM=EMPTY. Outputs are held at these values while rst_n is low. Any in-flight result is discarded.
- FSM: EMPTY (output register free) and FULL (output register holds an unconsumed result).
  - EMPTY: a grant occurs if any req_valid is set; go to FULL.
  - FULL with out_ready=1 and a grant: stay FULL and load the new result in the same cycle (full throughput, 1 result/cycle).
  - FULL with out_ready=1 and no request: go to EMPTY.
  - FULL with out_ready=0: hold out_data/out_id stable; req_ready=0.
- can_accept = (state==EMPTY) | out_ready.
- req_ready is combinational: one-hot grant among req_valid, gated by can_accept. The handshake completes on req_valid[i] & req_ready[i].
- Arbitration: the search starts at the rr pointer and wraps modulo NUM_REQ; the first valid requester wins. After a completed handshake, the pointer becomes granted index+1 (wrapping NUM_REQ-1 to 0). With no handshake the pointer is unchanged.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepted transfers.
- Latency: 1 cycle from handshake to out_valid.
- Result: out_data = req_neg ? (~x + 1) mod 2^DATA_WIDTH : x.
  - Negating 0 gives 0.
  - Negating the most-negative value (1 followed by zeros) gives the same value.
- req_data/req_neg are sampled only on the handshake cycle. Requesters may deassert valid without handshake; no penalty.
- Requesters with index >= NUM_REQ do not exist; ID_WIDTH bits above the index are zero.

Optional Feature:
- Macro NEG_OVF_FLAG_EN.
- When defined:
  - Adds output port out_ovf (1 bit, reset 0), registered alongside out_data.
  - out_ovf = 1 when req_neg=1 and the operand is the most-negative value (negation overflow); otherwise 0.
- When undefined: the port is absent and there is no extra logic. All other behaviour is identical.

Decomposition:
- Shared package fpu_sched_pkg:
  - typedef sched_state_e {EMPTY, FULL};
  - function clog2-based ID width helper;
  - localparam default DATA_WIDTH=8.
- Natural sub-module rr_arbiter: parameter NUM_REQ. Inputs are the valid vector and an advance strobe; outputs are a one-hot grant and a binary index. It owns the pointer register on clk/rst_n.
- The negation datapath is one instance of two_complement on the granted operand, followed by a mux on req_neg.

Test Plan:
- Single requester: req0 valid, neg=1, data=0x05, out_ready=1. Expect out_data=0xFB, out_id=0 one cycle later; then neg=0, data=0x05 gives 0x05.
- Boundaries: negate 0x00 gives 0x00; negate 0x80 gives 0x80 (out_ovf=1 with NEG_OVF_FLAG_EN); negate 0xFF gives 0x01.
- All 4 requesters held valid, out_ready=1. Expect grants in order 0,1,2,3,0… and out_id sequence 0,1,2,3,0 at one per cycle.
- Back-pressure: out_ready=0 for 5 cycles with FULL. Expect out_data/out_id stable, req_ready=0000, pointer frozen; releasing out_ready resumes with the next requester.
- Reset mid-operation: assert rst_n low while FULL and requests pending. Expect out_valid=0 and req_ready=0 immediately (asynchronous). After release, the first grant goes to requester 0.
